// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// sequencer states and the packed stall/flush control word.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } ctrl_state_t;

   // One bit per stage-register control; hold (stall) and bubble (flush).
   typedef struct packed {
      logic stallF;
      logic stallD;
      logic stallE;
      logic stallM;
      logic flushD;
      logic flushE;
      logic flushM;
      logic flushW;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit bus: register addresses and status from the datapath in,
// stall/flush/forward controls back out.
interface pipeline_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
   ;
   reg_addr_t rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic      memReadE, regWriteM, regWriteW, pcSrcE, mdStartE;
   logic      dmemReqM, dmemReadyM;
   logic      stallF, stallD, stallE, stallM;
   logic      flushD, flushE, flushM, flushW;
   fwd_sel_t  forwardAE, forwardBE;
   logic      mdBusy, busErr;

   // Datapath side
   modport master (
      output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
      output memReadE, regWriteM, regWriteW, pcSrcE, mdStartE,
      output dmemReqM, dmemReadyM,
      input  stallF, stallD, stallE, stallM,
      input  flushD, flushE, flushM, flushW,
      input  forwardAE, forwardBE, mdBusy, busErr
   );

   // Hazard controller side
   modport slave (
      input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
      input  memReadE, regWriteM, regWriteW, pcSrcE, mdStartE,
      input  dmemReqM, dmemReadyM,
      output stallF, stallD, stallE, stallM,
      output flushD, flushE, flushM, flushW,
      output forwardAE, forwardBE, mdBusy, busErr
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Operand forwarding select for one stage-E source register.
// M wins over W because it holds the younger result.
module forward_unit
   import pipe_ctrl_pkg::*;
(
   input  reg_addr_t rsE,
   input  reg_addr_t rdM,
   input  reg_addr_t rdW,
   input  logic      regWriteM,
   input  logic      regWriteW,
   output fwd_sel_t  fwd
);

   // Pick the youngest in-flight producer of rsE; x0 is never forwarded.
   always_comb begin
      // NOTE: default first so every path assigns fwd and no latch is inferred.
      fwd = FWD_RF;
      if (regWriteM && (rdM != '0) && (rdM == rsE))
         fwd = FWD_MEM;
      else if (regWriteW && (rdW != '0) && (rdW == rsE))
         fwd = FWD_WB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/sequencing controller for the F/D/E/M/W pipeline:
// stall/flush priority, E-stage forwarding, mul/div occupancy FSM,
// dmem wait-state hold with sticky timeout, and a stall performance counter.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_LAT       = 4,
   parameter int DMEM_TIMEOUT = 255,
   parameter int CNT_W        = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_hazard_ctrl_if.slave hz,
   output logic [CNT_W-1:0]     stallCount
);

   localparam int MD_CNT_W = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;
   localparam int WAIT_W   = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
   localparam bit MD_MULTI = (MD_LAT > 1);
   localparam logic [MD_CNT_W-1:0] MD_LOAD   = MD_CNT_W'((MD_LAT > 1) ? MD_LAT - 2 : 0);
   localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);

   ctrl_state_t         state, stateNext;
   logic [MD_CNT_W-1:0] mdCnt;
   logic [WAIT_W-1:0]   waitCnt;
   logic                busErrQ;
   logic                dmemStall, mdStart, mdStall, lwStall;
   ctrl_t               ctrl;

   forward_unit u_fwd_a (
      .rsE(hz.rs1E), .rdM(hz.rdM), .rdW(hz.rdW),
      .regWriteM(hz.regWriteM), .regWriteW(hz.regWriteW), .fwd(hz.forwardAE)
   );

   forward_unit u_fwd_b (
      .rsE(hz.rs2E), .rdM(hz.rdM), .rdW(hz.rdW),
      .regWriteM(hz.regWriteM), .regWriteW(hz.regWriteW), .fwd(hz.forwardBE)
   );

   // Hazard conditions. A pending dmem access freezes E, so branch, mul/div
   // start and load-use are all deferred until it completes.
   assign dmemStall = hz.dmemReqM & ~hz.dmemReadyM;
   assign mdStart   = MD_MULTI & (state == RUN) & hz.mdStartE & ~hz.pcSrcE & ~dmemStall;
   assign mdStall   = mdStart | ((state == MD_BUSY) && (mdCnt != '0));
   assign lwStall   = hz.memReadE & (hz.rdE != '0)
                    & ((hz.rdE == hz.rs1D) | (hz.rdE == hz.rs2D))
                    & ~dmemStall & ~hz.pcSrcE & (state == RUN);

   // Sequencer state register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking so all flops sample pre-edge values, independent of block order.
      if (reset) state <= RUN;
      else       state <= stateNext;
   end

   // Sequencer next state: enter MD_BUSY on an accepted multi-cycle op,
   // leave once the latency counter has drained.
   always_comb begin
      stateNext = state;
      case (state)
         RUN:     if (mdStart) stateNext = MD_BUSY;
         MD_BUSY: if (mdCnt == '0) stateNext = RUN;
         default: stateNext = RUN;
      endcase
   end

   // Stall/flush outputs in priority order: reset, dmem wait, branch, mul/div, load-use.
   always_comb begin
      ctrl = CTRL_IDLE;
      if (reset) begin
         ctrl = CTRL_IDLE;
      end else if (dmemStall) begin
         ctrl.stallF = 1'b1; ctrl.stallD = 1'b1; ctrl.stallE = 1'b1; ctrl.stallM = 1'b1;
         ctrl.flushW = 1'b1;
      end else if (hz.pcSrcE) begin
         ctrl.flushD = 1'b1; ctrl.flushE = 1'b1;
      end else if (mdStall) begin
         ctrl.stallF = 1'b1; ctrl.stallD = 1'b1; ctrl.stallE = 1'b1;
         ctrl.flushM = 1'b1;
      end else if (lwStall) begin
         ctrl.stallF = 1'b1; ctrl.stallD = 1'b1;
         ctrl.flushE = 1'b1;
      end
   end

   // Mul/div latency counter; keeps draining even while dmem holds the pipe.
   always_ff @(posedge clk) begin
      if (reset)                                 mdCnt <= '0;
      else if (mdStart)                          mdCnt <= MD_LOAD;
      else if (state == MD_BUSY && mdCnt != '0)  mdCnt <= mdCnt - MD_CNT_W'(1);
   end

   // Consecutive dmem wait cycles; parks at the timeout value so it cannot wrap.
   always_ff @(posedge clk) begin
      if (reset || !dmemStall)        waitCnt <= '0;
      else if (waitCnt != WAIT_LAST)  waitCnt <= waitCnt + WAIT_W'(1);
   end

   // Sticky bus error once a wait reaches the timeout; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset)                                  busErrQ <= 1'b0;
      else if (dmemStall && waitCnt == WAIT_LAST) busErrQ <= 1'b1;
   end

   // Saturating count of front-end stall cycles.
   always_ff @(posedge clk) begin
      if (reset)                             stallCount <= '0;
      else if (ctrl.stallF && !(&stallCount)) stallCount <= stallCount + CNT_W'(1);
   end

   assign hz.stallF = ctrl.stallF;
   assign hz.stallD = ctrl.stallD;
   assign hz.stallE = ctrl.stallE;
   assign hz.stallM = ctrl.stallM;
   assign hz.flushD = ctrl.flushD;
   assign hz.flushE = ctrl.flushE;
   assign hz.flushM = ctrl.flushM;
   assign hz.flushW = ctrl.flushW;
   assign hz.mdBusy = (state == MD_BUSY);
   assign hz.busErr = busErrQ;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (MD_LAT=4, DMEM_TIMEOUT=4, CNT_W=4).
// Control word order: {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}.
module tb_pipeline_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam logic [7:0] C_NONE = 8'h00;
   localparam logic [7:0] C_LW   = 8'hC4;  // stallF, stallD, flushE
   localparam logic [7:0] C_BR   = 8'h0C;  // flushD, flushE
   localparam logic [7:0] C_MD   = 8'hE2;  // stallF, stallD, stallE, flushM
   localparam logic [7:0] C_DMEM = 8'hF1;  // stallF..stallM, flushW

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] stallCount;
   logic [7:0] ctl;
   int         vectors = 0;
   int         miscompares = 0;

   pipeline_hazard_ctrl_if hz ();

   pipeline_hazard_ctrl #(.MD_LAT(4), .DMEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .hz(hz), .stallCount(stallCount)
   );

   always #5 clk = ~clk;

   assign ctl = {hz.stallF, hz.stallD, hz.stallE, hz.stallM,
                 hz.flushD, hz.flushE, hz.flushM, hz.flushW};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      hz.rs1D = '0; hz.rs2D = '0; hz.rs1E = '0; hz.rs2E = '0;
      hz.rdE = '0; hz.rdM = '0; hz.rdW = '0;
      hz.memReadE = 1'b0; hz.regWriteM = 1'b0; hz.regWriteW = 1'b0;
      hz.pcSrcE = 1'b0; hz.mdStartE = 1'b0;
      hz.dmemReqM = 1'b0; hz.dmemReadyM = 1'b0;
   endtask

   // Advance to just after the next rising edge, then let combinational logic settle.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic dmem_wait();
      hz.dmemReqM = 1'b1; hz.dmemReadyM = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with every hazard input active: outputs must stay quiet.
      reset = 1'b1;
      idle_inputs();
      dmem_wait();
      hz.pcSrcE = 1'b1; hz.mdStartE = 1'b1;
      hz.memReadE = 1'b1; hz.rdE = 5'd7; hz.rs2D = 5'd7;
      settle();
      check("reset_ctl0", ctl, C_NONE);
      cyc();
      settle();
      check("reset_ctl1", ctl, C_NONE);
      check("reset_mdbusy", hz.mdBusy, 0);
      check("reset_buserr", hz.busErr, 0);
      check("reset_cnt", stallCount, 0);
      cyc();
      reset = 1'b0;
      idle_inputs();
      settle();
      check("run_idle", ctl, C_NONE);

      // Forwarding priority and x0 / write-enable qualification.
      hz.rs1E = 5'd5; hz.rs2E = 5'd6;
      hz.regWriteM = 1'b1; hz.rdM = 5'd5;
      hz.regWriteW = 1'b1; hz.rdW = 5'd5;
      settle();
      check("fwdA_mem_prio", 32'(hz.forwardAE), 2);
      check("fwdB_none", 32'(hz.forwardBE), 0);
      hz.rdM = 5'd0;
      settle();
      check("fwdA_wb_rdM0", 32'(hz.forwardAE), 1);
      hz.rdW = 5'd0;
      settle();
      check("fwdA_rf_rdW0", 32'(hz.forwardAE), 0);
      hz.rdM = 5'd6; hz.regWriteM = 1'b0; hz.rdW = 5'd6;
      settle();
      check("fwdB_wb_noWrM", 32'(hz.forwardBE), 1);
      hz.regWriteM = 1'b1; hz.rdM = 5'd5;
      settle();
      check("fwdA_mem", 32'(hz.forwardAE), 2);
      check("fwdB_wb", 32'(hz.forwardBE), 1);
      idle_inputs();

      // Load-use: one bubble, then clear.
      hz.memReadE = 1'b1; hz.rdE = 5'd7; hz.rs2D = 5'd7;
      settle();
      check("lw_rs2", ctl, C_LW);
      check("lw_cnt0", stallCount, 0);
      cyc();
      hz.memReadE = 1'b0;
      settle();
      check("lw_release", ctl, C_NONE);
      check("lw_cnt1", stallCount, 1);
      cyc();
      hz.memReadE = 1'b1; hz.rdE = 5'd0; hz.rs1D = 5'd0; hz.rs2D = 5'd0;
      settle();
      check("lw_rd0", ctl, C_NONE);
      cyc();
      hz.rdE = 5'd3; hz.rs1D = 5'd3; hz.rs2D = 5'd9;
      settle();
      check("lw_rs1", ctl, C_LW);
      cyc();

      // Branch beats load-use and suppresses a mul/div start.
      hz.pcSrcE = 1'b1; hz.mdStartE = 1'b1;
      hz.memReadE = 1'b1; hz.rdE = 5'd7; hz.rs1D = 5'd0; hz.rs2D = 5'd7;
      settle();
      check("br_over_lw", ctl, C_BR);
      cyc();
      idle_inputs();
      settle();
      check("br_no_md", hz.mdBusy, 0);
      check("br_ctl_after", ctl, C_NONE);
      check("br_cnt", stallCount, 2);

      // Mul/div, MD_LAT=4: three stall cycles, mdStartE held through MD_BUSY.
      do_reset();
      hz.mdStartE = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         check($sformatf("md_ctl%0d", i), ctl, (i < 3) ? C_MD : C_NONE);
         check($sformatf("md_busy%0d", i), hz.mdBusy, (i >= 1) ? 1 : 0);
         cyc();
      end
      hz.mdStartE = 1'b0;
      settle();
      check("md_done_busy", hz.mdBusy, 0);
      check("md_done_ctl", ctl, C_NONE);
      check("md_cnt", stallCount, 3);

      // Mul/div counter keeps draining under a dmem wait.
      hz.mdStartE = 1'b1;
      settle();
      check("mdw_start", ctl, C_MD);
      cyc();
      hz.mdStartE = 1'b0;
      dmem_wait();
      settle();
      check("mdw_dmem", ctl, C_DMEM);
      check("mdw_busy1", hz.mdBusy, 1);
      cyc();
      idle_inputs();
      settle();
      check("mdw_last_stall", ctl, C_MD);
      cyc();
      settle();
      check("mdw_exit", ctl, C_NONE);
      check("mdw_busy3", hz.mdBusy, 1);
      cyc();
      settle();
      check("mdw_run", hz.mdBusy, 0);
      check("mdw_cnt", stallCount, 6);

      // Dmem wait with a pending branch: hold 5 cycles, branch fires on ready.
      do_reset();
      dmem_wait();
      hz.pcSrcE = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         check($sformatf("dw_ctl%0d", i), ctl, C_DMEM);
         check($sformatf("dw_err%0d", i), hz.busErr, (i >= 4) ? 1 : 0);
         cyc();
      end
      hz.dmemReadyM = 1'b1;
      settle();
      check("dw_branch", ctl, C_BR);
      check("dw_err_sticky", hz.busErr, 1);
      check("dw_cnt", stallCount, 5);
      cyc();
      idle_inputs();
      settle();
      check("dw_idle", ctl, C_NONE);

      // Wait counter clears between waits: 3 + 3 cycles never time out.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         if (i == 3) begin
            hz.dmemReqM = 1'b1; hz.dmemReadyM = 1'b1;
         end else begin
            dmem_wait();
         end
         cyc();
      end
      idle_inputs();
      settle();
      check("wc_no_err", hz.busErr, 0);
      cyc();

      // Timeout: six wait cycles, error from the fifth on, sticky, cleared by reset.
      dmem_wait();
      for (int i = 0; i < 6; i++) begin
         settle();
         check($sformatf("to_err%0d", i), hz.busErr, (i >= 4) ? 1 : 0);
         cyc();
      end
      hz.dmemReadyM = 1'b1;
      settle();
      check("to_sticky", hz.busErr, 1);
      check("to_ready_ctl", ctl, C_NONE);
      cyc();
      do_reset();
      settle();
      check("to_reset_err", hz.busErr, 0);
      check("to_reset_busy", hz.mdBusy, 0);

      // Reset in the middle of MD_BUSY returns straight to RUN.
      hz.mdStartE = 1'b1;
      cyc();
      cyc();
      settle();
      check("mr_busy", hz.mdBusy, 1);
      do_reset();
      settle();
      check("mr_run", hz.mdBusy, 0);
      check("mr_cnt", stallCount, 0);

      // Stall counter saturates at all-ones (CNT_W=4).
      dmem_wait();
      for (int i = 0; i < 20; i++) cyc();
      idle_inputs();
      settle();
      check("sat_cnt", stallCount, 15);
      cyc();
      settle();
      check("sat_hold", stallCount, 15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
